sie_phase_sequencer: RTL
========================

SIE_PHASE_SEQUENCER -- requirements
Module: sie_phase_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 18, the signed Q14 gain output width.
REQ-002 SHALL have parameter CW, default 16, the duration/timer width in clk_en ticks.
REQ-003 SHALL have clk, input, 1: rising-edge clock.
REQ-004 SHALL have rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have clk_en, input, 1: 4 kHz update strobe; all state advances only when high.
REQ-006 SHALL have trigger, input, 1: ignition request, sampled on clk_en.
REQ-007 SHALL have abort, input, 1: force early termination, sampled on clk_en.
REQ-008 SHALL have dur_p2, dur_p3, dur_p4, dur_p5, dur_p6, dur_refr, inputs, CW each: phase durations in ticks.
REQ-009 SHALL have phase, output, 3: 0 IDLE, 2..6 event phases, 7 REFRACTORY (1, 5-unused codes never driven... 1 never driven).
REQ-010 SHALL have phase_timer, output, CW: ticks elapsed in current phase.
REQ-011 SHALL have sie_active, output, 1: high when phase is 2..6.
REQ-012 SHALL have sie_gain, output, signed WIDTH: Q14 coupling gain for the current phase.
REQ-013 SHALL have event_done, output, 1: one-clk pulse on entry to REFRACTORY.
REQ-014 SHALL have aborted, output, 1: one-clk pulse coincident with event_done when entry was via abort.
REQ-015 SHALL have trig_missed, output, 1: one-clk pulse when trigger is seen outside IDLE.
REQ-016 SHALL have event_count, output, CW: count of events started, wraps at 2^CW.

Function
REQ-017 All outputs SHALL be registered; no state or output changes on cycles with clk_en low, except single-cycle pulses returning to 0.
REQ-018 Pulses (event_done, aborted, trig_missed) SHALL be high for exactly one clk cycle, on the clk_en cycle of the causing event.
REQ-019 IDLE with trigger=1 on clk_en SHALL move to phase 2 next cycle, timer=0, event_count+1, and snapshot all six durations.
REQ-020 Durations SHALL be used only from the snapshot; input changes during an event/refractory SHALL have no effect until the next trigger.
REQ-021 Each phase p SHALL last L=max(snapshot_dur_p,1) ticks: timer counts 0..L-1, then advance on the tick where timer==L-1, timer reset to 0.
REQ-022 Sequence SHALL be 2->3->4->5->6->REFRACTORY->IDLE; REFRACTORY uses dur_refr snapshot with the same rule.
REQ-023 abort=1 on clk_en in phases 2..6 SHALL enter REFRACTORY next cycle (timer=0), with event_done=1 and aborted=1.
REQ-024 abort in IDLE or REFRACTORY SHALL be ignored.
REQ-025 abort and natural phase-6 completion on the same tick SHALL be treated as abort (aborted=1).
REQ-026 trigger in any phase other than IDLE SHALL pulse trig_missed and not alter sequencing; the REFRACTORY->IDLE tick counts as non-IDLE.
REQ-027 trigger is level-sampled: held high in IDLE starts an event on the first clk_en tick only (IDLE left immediately).
REQ-028 sie_gain SHALL be: IDLE 0, p2 4096, p3 16384, p4 16384, p5 8192, p6 4096, REFRACTORY 0, updated same cycle as phase.
REQ-029 Timer SHALL not overflow: L<=2^CW-1 guarantees the terminal compare is reached.

Reset
REQ-030 On rst: phase=0, phase_timer=0, sie_active=0, sie_gain=0, event_done=0, aborted=0, trig_missed=0, event_count=0, snapshots=0.
REQ-031 rst asserted mid-event SHALL return immediately to IDLE with no event_done pulse; first post-reset trigger starts a fresh event.

Verification
REQ-032 Durations 2,3,1,4,2,refr 5, clk_en every cycle, trigger one tick: phase 2(2),3(3),4(1),5(4),6(2),7(5) ticks, then 0; event_done at tick 12; event_count=1.
REQ-033 Same setup, abort during phase 4: REFRACTORY next cycle, event_done=aborted=1, sie_gain 0, then IDLE after 5 ticks.
REQ-034 Change dur_p5 to 100 during phase 3: phase 5 still lasts 4 ticks; next event uses 100.
REQ-035 All durations 0: each phase lasts 1 tick, total 6 ticks to IDLE.
REQ-036 trigger during REFRACTORY and held through IDLE: trig_missed pulses each non-IDLE tick, new event starts first IDLE tick, event_count=2.
REQ-037 clk_en every 4th cycle: timer and phase change only on strobe cycles; rst mid-phase-5 -> all outputs reset values, no event_done.

Source files
------------

// File: rtl/sie_phase_sequencer.sv
// ---------------------------------------------------------------------------
// sie_phase_sequencer
//
// Steps a stimulation event through five coupling phases (2..6) and a
// refractory phase (7), then returns to IDLE (0). Each phase lasts a number
// of clk_en ticks taken from a snapshot of the duration inputs. The snapshot
// is captured when the event is triggered. Each phase has a fixed Q14
// coupling gain.
//
// Parameters
//   WIDTH        width of the signed Q14 gain output
//   CW           width of the durations, the phase timer and the event counter
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   clk_en       update strobe; state only advances when high
//   trigger      ignition request (level, sampled on clk_en)
//   abort        early termination request (sampled on clk_en)
//   dur_p2..p6   phase durations in ticks
//   dur_refr     refractory duration in ticks
//   phase        0 IDLE, 2..6 event phases, 7 REFRACTORY
//   phase_timer  ticks elapsed in the current phase
//   sie_active   high while phase is 2..6
//   sie_gain     Q14 coupling gain of the current phase
//   event_done   one-cycle pulse on entry to REFRACTORY
//   aborted      one-cycle pulse with event_done when entry was via abort
//   trig_missed  one-cycle pulse when trigger is seen outside IDLE
//   event_count  number of events started (wraps)
// ---------------------------------------------------------------------------
module sie_phase_sequencer #(
    parameter int WIDTH = 18,
    parameter int CW    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    trigger,
    input  logic                    abort,
    input  logic [CW-1:0]           dur_p2,
    input  logic [CW-1:0]           dur_p3,
    input  logic [CW-1:0]           dur_p4,
    input  logic [CW-1:0]           dur_p5,
    input  logic [CW-1:0]           dur_p6,
    input  logic [CW-1:0]           dur_refr,
    output logic [2:0]              phase,
    output logic [CW-1:0]           phase_timer,
    output logic                    sie_active,
    output logic signed [WIDTH-1:0] sie_gain,
    output logic                    event_done,
    output logic                    aborted,
    output logic                    trig_missed,
    output logic [CW-1:0]           event_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_P4   = 3'd4,
        S_P5   = 3'd5,
        S_P6   = 3'd6,
        S_REFR = 3'd7
    } state_t;

    localparam int NDUR = 6;  // p2..p6, refractory

    state_t                   state_reg, state_next;
    logic [CW-1:0]            timer_reg, timer_next;
    logic [CW-1:0]            count_reg, count_next;
    logic [CW-1:0]            snap_reg  [NDUR];
    logic [CW-1:0]            snap_next [NDUR];
    logic [CW-1:0]            dur_in    [NDUR];
    logic [CW-1:0]            term      [NDUR];
    logic                     done_reg, done_next;
    logic                     aborted_reg, aborted_next;
    logic                     missed_reg, missed_next;
    logic                     active_reg, active_next;
    logic signed [WIDTH-1:0]  gain_reg, gain_next;
    logic [CW-1:0]            term_cur;
    logic                     at_term;

    assign dur_in[0] = dur_p2;
    assign dur_in[1] = dur_p3;
    assign dur_in[2] = dur_p4;
    assign dur_in[3] = dur_p5;
    assign dur_in[4] = dur_p6;
    assign dur_in[5] = dur_refr;

    // Terminal timer value per phase. A zero duration is treated as one
    // tick, so the terminal value is max(d,1)-1.
    genvar gi;
    generate
        for (gi = 0; gi < NDUR; gi++) begin : g_term
            assign term[gi] = (snap_reg[gi] == '0) ? '0 : snap_reg[gi] - 1'b1;
        end
    endgenerate

    always_comb begin
        term_cur = '0;
        case (state_reg)
            S_P2:    term_cur = term[0];
            S_P3:    term_cur = term[1];
            S_P4:    term_cur = term[2];
            S_P5:    term_cur = term[3];
            S_P6:    term_cur = term[4];
            S_REFR:  term_cur = term[5];
            default: term_cur = '0;
        endcase
    end

    assign at_term = (timer_reg == term_cur);

    // Next-state logic. Pulses default to 0 every clk, so they drop back
    // on the cycle after they were raised, whether or not clk_en is high.
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        count_next   = count_reg;
        snap_next    = snap_reg;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        missed_next  = 1'b0;

        if (clk_en) begin
            case (state_reg)
                S_IDLE: begin
                    if (trigger) begin
                        state_next = S_P2;
                        timer_next = '0;
                        count_next = count_reg + 1'b1;
                        snap_next  = dur_in;
                    end
                end
                S_REFR: begin
                    // The tick leaving REFRACTORY still counts as non-IDLE.
                    missed_next = trigger;
                    if (at_term) begin
                        state_next = S_IDLE;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
                default: begin
                    missed_next = trigger;
                    // Abort takes priority over natural completion.
                    if (abort) begin
                        state_next   = S_REFR;
                        timer_next   = '0;
                        done_next    = 1'b1;
                        aborted_next = 1'b1;
                    end else if (at_term) begin
                        timer_next = '0;
                        case (state_reg)
                            S_P2:    state_next = S_P3;
                            S_P3:    state_next = S_P4;
                            S_P4:    state_next = S_P5;
                            S_P5:    state_next = S_P6;
                            default: state_next = S_REFR;
                        endcase
                        done_next = (state_reg == S_P6);
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    // Gain and active flag follow the next state, so they update in the same
    // cycle as phase.
    always_comb begin
        active_next = 1'b0;
        gain_next   = '0;
        case (state_next)
            S_P2: begin active_next = 1'b1; gain_next = WIDTH'(4096);  end
            S_P3: begin active_next = 1'b1; gain_next = WIDTH'(16384); end
            S_P4: begin active_next = 1'b1; gain_next = WIDTH'(16384); end
            S_P5: begin active_next = 1'b1; gain_next = WIDTH'(8192);  end
            S_P6: begin active_next = 1'b1; gain_next = WIDTH'(4096);  end
            default: begin active_next = 1'b0; gain_next = '0; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            count_reg   <= '0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            missed_reg  <= 1'b0;
            active_reg  <= 1'b0;
            gain_reg    <= '0;
            for (int i = 0; i < NDUR; i++) begin
                snap_reg[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            count_reg   <= count_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
            missed_reg  <= missed_next;
            active_reg  <= active_next;
            gain_reg    <= gain_next;
            for (int i = 0; i < NDUR; i++) begin
                snap_reg[i] <= snap_next[i];
            end
        end
    end

    assign phase       = state_reg;
    assign phase_timer = timer_reg;
    assign sie_active  = active_reg;
    assign sie_gain    = gain_reg;
    assign event_done  = done_reg;
    assign aborted     = aborted_reg;
    assign trig_missed = missed_reg;
    assign event_count = count_reg;

endmodule
